gates_seq_checker: RTL and testbench

Self-checking sequencer for the three-gate block (AND, OR and NOT on inputs a, b, c; outputs t0, t1, t2). On start it steps through all 8 input vectors, holds each for a settle window, then compares the gate outputs against golden values. It counts mismatches, latches the first failure and reports done/pass. It replaces the hand-written delay-based stimulus with a clocked, repeatable built-in test.

---
 rtl/gates_seq_checker_pkg.sv | 16 +
 rtl/gates_seq_checker_golden.sv | 12 +
 rtl/gates_seq_checker.sv | 177 +++++++++++++++++
 tb/tb_gates_seq_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gates_seq_checker_pkg.sv
// Shared definitions for the gate-block built-in sequencer: FSM encoding and
// vector-space sizing.
package gates_seq_checker_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int NUM_VECTORS = 8;
   localparam int VEC_W       = 3;

endpackage

// File: rtl/gates_seq_checker_golden.sv
// Golden model of the three-gate block: {a,b,c} -> {a&b, a|b, ~c}.
// Purely combinational so it can also serve as a reference in benches.
module gates_golden
   import gates_seq_checker_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic [2:0]       expected
);

   assign expected = {vec[2] & vec[1], vec[2] | vec[1], ~vec[0]};

endmodule

// File: rtl/gates_seq_checker.sv
// Clocked built-in test for the AND/OR/NOT gate block: sweeps all 8 input
// vectors, waits a settle window per vector, and scores the gate outputs.
module gates_seq_checker
   import gates_seq_checker_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             c,
   input  logic             t0,
   input  logic             t1,
   input  logic             t2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [2:0]       fail_vec,
   output logic [2:0]       fail_bits
);

   localparam int SET_W = 4;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [VEC_W-1:0]   abc_q, abc_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fv_q, fv_d;
   logic [2:0]         fvec_q, fvec_d;
   logic [2:0]         fbits_q, fbits_d;

   logic [2:0]         expected;
   logic [2:0]         diff;
   logic               mismatch;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   gates_golden u_golden (
      .vec      (abc_q),
      .expected (expected)
   );

   // Compare against the registered stimulus so the check sees exactly what was held.
   assign diff     = {t0, t1, t2} ^ expected;
   assign mismatch = |diff;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      abc_d    = abc_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fv_d     = fv_q;
      fvec_d   = fvec_q;
      fbits_d  = fbits_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               err_d   = '0;
               fv_d    = 1'b0;
               fvec_d  = '0;
               fbits_d = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               vec_d   = '0;
               busy_d  = 1'b1;
               state_d = APPLY;
            end
         end
         APPLY: begin
            abc_d    = vec_q;
            settle_d = SET_W'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == '0) begin
               state_d = CHECK;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_d = sat_inc(err_q);
               if (!fv_q) begin
                  fv_d    = 1'b1;
                  fvec_d  = abc_q;
                  fbits_d = diff;
               end
            end
            if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = !mismatch && (err_q == '0);
               abc_d   = '0;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               state_d = APPLY;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything, including a coincident start; scoreboard is kept.
      if (abort) begin
         state_d  = IDLE;
         abc_d    = '0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         pass_d   = 1'b0;
         vec_d    = vec_q;
         settle_d = settle_q;
         err_d    = err_q;
         fv_d     = fv_q;
         fvec_d   = fvec_q;
         fbits_d  = fbits_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         abc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fv_q     <= 1'b0;
         fvec_q   <= '0;
         fbits_q  <= '0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         abc_q    <= abc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fv_q     <= fv_d;
         fvec_q   <= fvec_d;
         fbits_q  <= fbits_d;
      end
   end

   assign a          = abc_q[2];
   assign b          = abc_q[1];
   assign c          = abc_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;
   assign fail_bits  = fbits_q;

endmodule

// File: tb/tb_gates_seq_checker.sv
// Bench for gates_seq_checker: two instances (default and narrow-counter) driven
// by a faulty-gate model and scored against a timeline-based reference.
module tb_gates_seq_checker;

   localparam int S0 = 2, W0 = 4;
   localparam int S1 = 3, W1 = 2;

   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
   int fault = 0;
   logic [7:0][2:0] rnd_mask = '0;
   logic chk_en = 1'b0;
   int n_checks = 0, n_fail = 0;

   logic a0, b0, c0, t00, t10, t20, busy0, done0, pass0, fv0;
   logic [W0-1:0] err0;
   logic [2:0] fvec0, fbits0;
   logic a1, b1, c1, t01, t11, t21, busy1, done1, pass1, fv1;
   logic [W1-1:0] err1;
   logic [2:0] fvec1, fbits1;

   always #5 clk = ~clk;

   function automatic logic [2:0] gold(input logic [2:0] v);
      return {v[2] & v[1], v[2] | v[1], ~v[0]};
   endfunction

   // Gate block with a selectable fault: 1 t0 stuck-0, 2 t2 stuck-1, 3 all inverted, 4 random per-vector flips.
   function automatic logic [2:0] observed(input int f, input logic [7:0][2:0] m, input logic [2:0] v);
      logic [2:0] g;
      g = gold(v);
      case (f)
         1: return {1'b0, g[1:0]};
         2: return {g[2:1], 1'b1};
         3: return ~g;
         4: return g ^ m[v];
         default: return g;
      endcase
   endfunction

   always_comb {t00, t10, t20} = observed(fault, rnd_mask, {a0, b0, c0});
   always_comb {t01, t11, t21} = observed(fault, rnd_mask, {a1, b1, c1});

   gates_seq_checker #(.SETTLE_CYCLES(S0), .ERR_W(W0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a(a0), .b(b0), .c(c0), .t0(t00), .t1(t10), .t2(t20),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .fail_valid(fv0), .fail_vec(fvec0), .fail_bits(fbits0)
   );

   gates_seq_checker #(.SETTLE_CYCLES(S1), .ERR_W(W1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a(a1), .b(b1), .c(c1), .t0(t01), .t1(t11), .t2(t21),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .fail_valid(fv1), .fail_vec(fvec1), .fail_bits(fbits1)
   );

   // Reference: mode 0 idle, 1 running, 2 done; n = edges since the accepting edge.
   int per [2] = '{S0 + 2, S1 + 2};
   int wid [2] = '{W0, W1};
   int m_mode [2], m_n [2], m_kf [2], m_fault [2];
   logic [7:0][2:0] m_mask [2];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_mode[i]  <= 0;
            m_n[i]     <= 0;
            m_kf[i]    <= 0;
            m_fault[i] <= 0;
            m_mask[i]  <= '0;
         end else if (abort) begin
            if (m_mode[i] == 1) m_kf[i] <= m_n[i] / per[i];
            m_mode[i] <= 0;
         end else if (start && m_mode[i] != 1) begin
            m_mode[i]  <= 1;
            m_n[i]     <= 0;
            m_fault[i] <= fault;
            m_mask[i]  <= rnd_mask;
         end else if (m_mode[i] == 1) begin
            m_n[i] <= m_n[i] + 1;
            if (m_n[i] + 1 == 8 * per[i]) begin
               m_mode[i] <= 2;
               m_kf[i]   <= 8;
            end
         end
      end
   end

   // Scoreboard after the first k vectors of a sweep have been scored.
   function automatic void stats(input int f, input logic [7:0][2:0] m, input int k, input int w,
                                 output int cnt, output logic fv, output logic [2:0] fvec,
                                 output logic [2:0] fbits);
      logic [2:0] d;
      cnt = 0; fv = 1'b0; fvec = '0; fbits = '0;
      for (int u = 0; u < k; u++) begin
         d = observed(f, m, 3'(u)) ^ gold(3'(u));
         if (d != 3'b000) begin
            if (cnt < (1 << w) - 1) cnt++;
            if (!fv) begin
               fv = 1'b1; fvec = 3'(u); fbits = d;
            end
         end
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic [2:0] abc, input logic busy, input logic done,
                           input logic pass, input int err, input logic fv, input logic [2:0] fvec,
                           input logic [2:0] fbits);
      int k, cnt;
      logic efv;
      logic [2:0] efvec, efbits, eabc;
      if (m_mode[i] == 1) begin
         k = m_n[i] / per[i];
         if (m_n[i] == 0) eabc = 3'd0;
         else eabc = 3'((m_n[i] % per[i] == 0) ? k - 1 : k);
      end else begin
         k = m_kf[i];
         eabc = 3'd0;
      end
      stats(m_fault[i], m_mask[i], k, wid[i], cnt, efv, efvec, efbits);
      check($sformatf("u%0d_abc", i), abc, eabc);
      check($sformatf("u%0d_busy", i), busy, m_mode[i] == 1);
      check($sformatf("u%0d_done", i), done, m_mode[i] == 2);
      check($sformatf("u%0d_pass", i), pass, (m_mode[i] == 2) && cnt == 0);
      check($sformatf("u%0d_err_cnt", i), err, cnt);
      check($sformatf("u%0d_fail_valid", i), fv, efv);
      check($sformatf("u%0d_fail_vec", i), fvec, efvec);
      check($sformatf("u%0d_fail_bits", i), fbits, efbits);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, {a0, b0, c0}, busy0, done0, pass0, int'(err0), fv0, fvec0, fbits0);
         cmp_inst(1, {a1, b1, c1}, busy1, done1, pass1, int'(err1), fv1, fvec1, fbits1);
      end
   end

   task automatic start_sweep(input int f);
      @(negedge clk);
      fault = f;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Edges after the accepting edge until each instance raises done (-1 = timed out).
   task automatic wait_done_both(output int c0, output int c1);
      c0 = -1; c1 = -1;
      for (int i = 1; i <= 120; i++) begin
         @(posedge clk);
         #1;
         if (c0 < 0 && done0) c0 = i;
         if (c1 < 0 && done1) c1 = i;
         if (c0 >= 0 && c1 >= 0) break;
      end
   endtask

   task automatic outs_zero(input string name);
      check({name, "_u0"}, int'({a0, b0, c0, busy0, done0, pass0, fv0, fvec0, fbits0, err0}), 0);
      check({name, "_u1"}, int'({a1, b1, c1, busy1, done1, pass1, fv1, fvec1, fbits1, err1}), 0);
   endtask

   initial begin
      int l0, l1, r;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      outs_zero("reset");

      // Healthy gate block.
      start_sweep(0);
      check("busy_after_start", busy0, 1);
      wait_done_both(l0, l1);
      check("done_latency_u0", l0, 32);
      check("done_latency_u1", l1, 40);
      check("healthy_pass", pass0, 1);
      check("healthy_err", err0, 0);
      check("healthy_fv", fv0, 0);

      // t0 stuck at 0.
      start_sweep(1);
      wait_done_both(l0, l1);
      check("t0s0_err", err0, 2);
      check("t0s0_vec", fvec0, 3'b110);
      check("t0s0_bits", fbits0, 3'b100);
      check("t0s0_pass", pass0, 0);

      // t2 stuck at 1.
      start_sweep(2);
      wait_done_both(l0, l1);
      check("t2s1_err", err0, 4);
      check("t2s1_vec", fvec0, 3'b001);
      check("t2s1_bits", fbits0, 3'b001);

      // All outputs inverted: narrow counter saturates.
      start_sweep(3);
      wait_done_both(l0, l1);
      check("inv_err_u0", err0, 8);
      check("inv_err_u1", err1, 3);
      check("inv_vec_u1", fvec1, 3'b000);
      check("inv_bits_u1", fbits1, 3'b111);

      // Restart ignored while busy, then abort during vector 3 settle.
      repeat (5) @(negedge clk);
      start_sweep(3);
      repeat (5) @(posedge clk);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk) abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_busy", busy0, 0);
      check("abort_done", done0, 0);
      check("abort_abc", {a0, b0, c0}, 0);
      check("abort_err_kept", err0, 3);
      start_sweep(0);
      wait_done_both(l0, l1);
      check("post_abort_latency", l0, 32);
      check("post_abort_pass", pass0, 1);

      // Asynchronous reset between edges, mid-settle.
      start_sweep(2);
      repeat (5) @(posedge clk);
      check("pre_rst_busy", busy0, 1);
      #2 rst_n = 1'b0;
      #1 outs_zero("async_rst");
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      start_sweep(0);
      wait_done_both(l0, l1);
      check("post_rst_latency", l0, 32);
      check("post_rst_pass", pass0, 1);

      // Randomized sweeps, faults and aborts.
      for (int run = 0; run < 10; run++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         @(negedge clk);
         for (int v = 0; v < 8; v++) rnd_mask[v] = 3'($urandom_range(0, 7));
         start_sweep($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(1, 45);
            repeat (r - 1) @(posedge clk);
            @(negedge clk);
            abort = 1'b1;
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 abort = 1'b0;
            start = 1'b0;
            check("rand_abort_busy", busy0, 0);
         end else begin
            wait_done_both(l0, l1);
            check("rand_latency_u0", l0, 32);
            check("rand_latency_u1", l1, 40);
         end
         repeat (2) @(negedge clk);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
